fp_sum_collector: RTL and testbench

- Sits directly downstream of fp_adder_pipeline and captures its sum output into a small result FIFO with a ready/valid output interface.
- fp_adder_pipeline has no valid, stall or reset, so this block does three things:
  - tracks which cycles carried real operands, via a tag delay line matched to the adder latency;
  - gates new issues with a credit check, so a result never arrives without a free FIFO slot;
  - classifies each stored sum.

---
 rtl/fp_sum_collector.sv | 119 +++++++++++
 tb/tb_fp_sum_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_sum_collector                                                |
// | Purpose  : Captures the sum output of fp_adder_pipeline (which has no      |
// |            valid, stall or reset) into a small result FIFO. A tag delay    |
// |            line marks which adder output cycles carry real results, and    |
// |            a credit check throttles issue so every result finds a slot.    |
// |            Each stored sum is classified as {nan, inf, zero, sign}.        |
// | Ports    : clk, rst_n (sync, active-low)                                   |
// |            issue_valid / issue_ready : operand issue handshake            |
// |            add_sum                   : adder sum output                    |
// |            out_valid / out_ready     : result FIFO head handshake          |
// |            out_data, out_flags       : head sum and its classification    |
// |            out_level                 : number of stored entries            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fp_sum_collector #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [31:0]       add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_flags,
  output logic [ADDR_W:0]   out_level
);

  localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] c_depth_ext = (ADDR_W+2)'(DEPTH);

  // Tag delay line: bit 0 is loaded on accept, bit LATENCY leaves the line
  // in the cycle the matching sum sits on add_sum.
  logic [LATENCY:0]   r_tag;
  logic [ADDR_W:0]    r_inflight;
  logic [ADDR_W:0]    r_level;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [35:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_write;
  logic               w_pop;
  logic [ADDR_W+1:0]  w_committed;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic [3:0]         w_flags;

  // Credits cover both stored entries and results still inside the adder,
  // so a tagged result can never arrive at a full FIFO.
  assign w_committed = {1'b0, r_level} + {1'b0, r_inflight};
  assign issue_ready = rst_n && (w_committed < c_depth_ext);
  assign w_accept    = issue_valid && issue_ready;
  assign w_write     = r_tag[LATENCY];
  assign out_valid   = (r_level != '0);
  assign w_pop       = out_valid && out_ready;
  assign out_level   = r_level;

  // Empty FIFO presents zeros rather than a stale entry.
  assign out_data    = out_valid ? r_mem[r_rd_ptr][31:0]  : 32'h0;
  assign out_flags   = out_valid ? r_mem[r_rd_ptr][35:32] : 4'h0;

  // Classification of the incoming sum; denormals only report sign.
  assign w_exp   = add_sum[30:23];
  assign w_frac  = add_sum[22:0];
  assign w_flags = {(w_exp == 8'hFF) && (w_frac != '0),
                    (w_exp == 8'hFF) && (w_frac == '0),
                    (w_exp == 8'h00) && (w_frac == '0),
                    add_sum[31]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag      <= '0;
      r_inflight <= '0;
      r_level    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_tag <= {r_tag[LATENCY-1:0], w_accept};

      case ({w_accept, w_write})
        2'b10:   r_inflight <= r_inflight + (ADDR_W+1)'(1);
        2'b01:   r_inflight <= r_inflight - (ADDR_W+1)'(1);
        default: r_inflight <= r_inflight;
      endcase

      case ({w_write, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase

      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Storage needs no reset: r_level gates everything read from it.
  always_ff @(posedge clk) begin
    if (rst_n && w_write) begin
      r_mem[r_wr_ptr] <= {w_flags, add_sum};
    end
  end

  // The credit rule must make a write into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(w_write && (r_level == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_sum_collector                                             |
// | Purpose  : Self-checking bench for fp_sum_collector. A behavioural model   |
// |            of the adder delays a bench-supplied sum by LATENCY edges and   |
// |            drives random garbage in idle cycles. Directed vectors carry    |
// |            hand-computed sums and flags.                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fp_sum_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_sum;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  out_level;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] bp_sums [8];
  logic [31:0] adder_pipe [6];

  always #5 clk = ~clk;

  fp_sum_collector #(.LATENCY(5), .DEPTH(8), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .add_sum     (add_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .out_level   (out_level)
  );

  // Adder model: operands sampled at edge k give a sum on add_sum after
  // edge k+5. Idle cycles carry random garbage; the adder never resets.
  always @(posedge clk) begin
    adder_pipe[0] <= issue_valid ? issue_sum : $urandom();
    for (int i = 1; i < 6; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign add_sum = adder_pipe[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One issue, result visible exactly 6 edges later, then popped.
  task automatic single_issue(input string tag, input logic [31:0] s, input logic [3:0] f);
    check({tag, "_ready"}, 32'(issue_ready), 32'd1);
    issue_valid = 1'b1;
    issue_sum   = s;
    tick;
    issue_valid = 1'b0;
    repeat (5) tick;
    check({tag, "_valid_at5"}, 32'(out_valid), 32'd0);
    tick;
    check({tag, "_valid_at6"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},      out_data,        s);
    check({tag, "_flags"},     32'(out_flags),  32'(f));
    check({tag, "_level1"},    32'(out_level),  32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_level0"},    32'(out_level),  32'd0);
    check({tag, "_valid_pop"}, 32'(out_valid),  32'd0);
  endtask

  // Back-to-back issues of vecs[first +: n] with the consumer always ready;
  // result c-6 must be at the head right after edge k+c.
  task automatic run_stream(input int first, input int n);
    out_ready = 1'b1;
    for (int c = 0; c < n + 8; c++) begin
      if (c < n) begin
        check($sformatf("stream_ready_%0d", first + c), 32'(issue_ready), 32'd1);
        issue_valid = 1'b1;
        issue_sum   = vecs[first + c].sum;
      end else begin
        issue_valid = 1'b0;
      end
      tick;
      if (c >= 6 && c < n + 6) begin
        check($sformatf("stream_valid_%0d", first + c - 6), 32'(out_valid), 32'd1);
        check($sformatf("stream_data_%0d",  first + c - 6), out_data, vecs[first + c - 6].sum);
        check($sformatf("stream_flags_%0d", first + c - 6), 32'(out_flags),
              32'(vecs[first + c - 6].flags));
        check($sformatf("stream_level_%0d", first + c - 6), 32'(out_level), 32'd1);
      end else begin
        check($sformatf("stream_idle_c%0d", c), 32'(out_valid), 32'd0);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepts;

    vecs[0]  = '{32'h43858000, 4'b0000};
    vecs[1]  = '{32'h41200000, 4'b0000};
    vecs[2]  = '{32'h42080000, 4'b0000};
    vecs[3]  = '{32'hC3AE8000, 4'b0001};
    vecs[4]  = '{32'h00000000, 4'b0010};
    vecs[5]  = '{32'hC2EA0000, 4'b0001};
    vecs[6]  = '{32'hC1240000, 4'b0001};
    vecs[7]  = '{32'h43520000, 4'b0000};
    vecs[8]  = '{32'h7F800000, 4'b0100};
    vecs[9]  = '{32'hFF800000, 4'b0101};
    vecs[10] = '{32'h7FC00000, 4'b1000};
    vecs[11] = '{32'h00000001, 4'b0000};
    for (int i = 0; i < 8; i++) bp_sums[i] = 32'h3F800000 + 32'(i);

    // Reset
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_sum   = 32'h0;
    out_ready   = 1'b0;
    tick;
    tick;
    check("rst_valid", 32'(out_valid),   32'd0);
    check("rst_level", 32'(out_level),   32'd0);
    check("rst_ready", 32'(issue_ready), 32'd0);
    check("rst_data",  out_data,         32'd0);
    check("rst_flags", 32'(out_flags),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(issue_ready), 32'd1);

    // Single issue
    single_issue("single", 32'h43858000, 4'b0000);

    // Back-to-back, then special values
    run_stream(0, 8);
    run_stream(8, 4);

    // Backpressure: consumer stalled, issuer always presenting
    accepts     = 0;
    issue_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (issue_ready) begin
        if (accepts < 8) issue_sum = bp_sums[accepts];
        accepts++;
      end else begin
        issue_sum = 32'hBAD0_0000 + 32'(c);
      end
      tick;
      if (out_level > 4'd8) begin
        check("bp_level_bound", 32'(out_level), 32'd8);
      end
    end
    check("bp_accepts", 32'(accepts),     32'd8);
    check("bp_ready0",  32'(issue_ready), 32'd0);
    check("bp_level8",  32'(out_level),   32'd8);
    check("bp_head0",   out_data,         bp_sums[0]);
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_level7",  32'(out_level),   32'd7);
    check("bp_ready1",  32'(issue_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_data_%0d", i),  out_data,       bp_sums[i]);
      tick;
    end
    out_ready = 1'b0;
    check("bp_drained", 32'(out_level), 32'd0);

    // Reset mid-flight: three issues, reset sampled at edge k+3
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_sum   = vecs[i].sum;
      tick;
    end
    issue_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("mid_rst_ready", 32'(issue_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    for (int e = 4; e <= 12; e++) begin
      tick;
      check($sformatf("mid_valid_k%0d", e), 32'(out_valid), 32'd0);
      check($sformatf("mid_level_k%0d", e), 32'(out_level), 32'd0);
    end
    single_issue("post_rst", 32'hC2EA0000, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
